id_ex_operand_stage: RTL

Decode-side producer of the EX-stage operand-B interface for the RV32I pipeline. Decodes the IF/ID instruction, generates the sign-extended immediate and the 2-bit read-data-2 select, and registers them with register-file operands into the ID/EX pipeline register. Enforces valid/ready flow control, flush, and a one-cycle load-use bubble. Its outputs feed the EX-stage operand-B mux directly.

---
 rtl/id_ex_operand_stage_pkg.sv | 28 ++
 rtl/id_ex_operand_stage_imm_gen.sv | 26 ++
 rtl/id_ex_operand_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, operand-B select encodings and
// immediate formats for the ID/EX operand stage.
package riscv_id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_REG  = 2'b01;
  localparam logic [1:0] SEL_IMM  = 2'b10;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

endpackage

// File: rtl/id_ex_operand_stage_imm_gen.sv
// Combinational RV32I immediate generator; every format except U is
// sign-extended from instr[31], FMT_NONE yields zero.
module imm_gen
  import riscv_id_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand-B producer: decode, immediate, load-use bubble and pipeline
// register. Define ID_EX_BYPASS_EN to forward the writeback port into rs1/rs2.
module id_ex_operand_stage
  import riscv_id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_valid,
  output logic        if_id_ready,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_pc,
  input  logic [31:0] rf_read_data_1,
  input  logic [31:0] rf_read_data_2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_read_data_1,
  output logic [31:0] id_ex_read_data_2,
  output logic [31:0] id_ex_sign_ex,
  output logic [1:0]  id_ex_read_data_2_sel,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_branch,
  output logic        id_ex_illegal
);

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  imm_fmt_t    fmt;
  logic [1:0]  dec_sel;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
  logic        use_rs1, use_rs2;
  logic [31:0] imm;
  logic [31:0] op_data_1, op_data_2;
  logic        hazard, load, clear;

  assign opcode = if_id_instr[6:0];
  assign rd     = if_id_instr[11:7];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];

  always_comb begin
    fmt           = FMT_NONE;
    dec_sel       = SEL_NONE;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    case (opcode)
      OP_R: begin
        dec_sel = SEL_REG; dec_reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_sel = SEL_REG; fmt = FMT_B; dec_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_sel = SEL_IMM; fmt = FMT_I; dec_reg_write = 1'b1; use_rs1 = 1'b1;
        dec_mem_read = (opcode == OP_LOAD);
      end
      OP_STORE: begin
        dec_sel = SEL_IMM; fmt = FMT_S; dec_mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_sel = SEL_IMM; fmt = FMT_U; dec_reg_write = 1'b1;
      end
      OP_JAL: begin
        dec_sel = SEL_IMM; fmt = FMT_J; dec_reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (if_id_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

`ifdef ID_EX_BYPASS_EN
  always_comb begin
    op_data_1 = rf_read_data_1;
    op_data_2 = rf_read_data_2;
    if (wb_we && wb_rd != '0 && wb_rd == rs1) op_data_1 = wb_data;
    if (wb_we && wb_rd != '0 && wb_rd == rs2) op_data_2 = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign op_data_1 = rf_read_data_1;
  assign op_data_2 = rf_read_data_2;
`endif

  assign hazard = id_ex_valid && id_ex_mem_read && (id_ex_rd != '0) && if_id_valid &&
                  ((use_rs1 && rs1 == id_ex_rd) || (use_rs2 && rs2 == id_ex_rd));
  assign load        = ex_ready || !id_ex_valid;
  assign if_id_ready = load && !hazard && !flush;

  // Reset, flush, load-use bubble and empty slot all collapse to one clear
  // that zeroes every field, so no bubble can carry stray control bits.
  assign clear = rst || flush || (load && (hazard || !if_id_valid));

  always_ff @(posedge clk) begin
    if (clear) begin
      id_ex_valid           <= 1'b0;
      id_ex_pc              <= '0;
      id_ex_read_data_1     <= '0;
      id_ex_read_data_2     <= '0;
      id_ex_sign_ex         <= '0;
      id_ex_read_data_2_sel <= SEL_NONE;
      id_ex_rd              <= '0;
      id_ex_reg_write       <= 1'b0;
      id_ex_mem_read        <= 1'b0;
      id_ex_mem_write       <= 1'b0;
      id_ex_branch          <= 1'b0;
      id_ex_illegal         <= 1'b0;
    end else if (load) begin
      id_ex_valid           <= 1'b1;
      id_ex_pc              <= if_id_pc;
      id_ex_read_data_1     <= op_data_1;
      id_ex_read_data_2     <= op_data_2;
      id_ex_sign_ex         <= imm;
      id_ex_read_data_2_sel <= dec_sel;
      id_ex_rd              <= rd;
      id_ex_reg_write       <= dec_reg_write;
      id_ex_mem_read        <= dec_mem_read;
      id_ex_mem_write       <= dec_mem_write;
      id_ex_branch          <= dec_branch;
      id_ex_illegal         <= dec_illegal;
    end
  end

endmodule
